// File: rtl/bin_to_bcd_serial.sv
// Serial binary-to-BCD converter (double dabble), one operand bit per clock, MSB first.
// Results, overflow and leading-zero blanking mask are registered and held between completions.
module bin_to_bcd_serial #(
  parameter int unsigned BIN_WIDTH = 20,
  parameter int unsigned DIGITS    = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [BIN_WIDTH-1:0]   bin_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*DIGITS-1:0]    bcd_out,
  output logic                   overflow,
  output logic [DIGITS-1:0]      blank_mask
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [BIN_WIDTH-1:0] op_q;
  logic [BCD_W-1:0]     acc_q;
  logic                 ovf_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 start_ok_c;
  logic                 last_c;
  logic [BCD_W-1:0]     adj_c;
  logic [BCD_W-1:0]     acc_nxt_c;
  logic                 ovf_nxt_c;
  logic [DIGITS-1:0]    blank_c;
  logic                 all_zero_c;

  assign start_ok_c = start && (state != SHIFT);
  assign last_c     = (state == SHIFT) && (cnt_q == CNT_LAST);

  // Add-3 correction on every digit that would reach >=10 after doubling
  always_comb begin
    adj_c = acc_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        adj_c[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
    acc_nxt_c = {adj_c[BCD_W-2:0], op_q[BIN_WIDTH-1]};
    ovf_nxt_c = ovf_q | adj_c[BCD_W-1];
  end

  // Leading-zero mask of the finished accumulator; digit 0 is never blanked
  always_comb begin
    blank_c    = '0;
    all_zero_c = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      all_zero_c = all_zero_c & (acc_nxt_c[4*k +: 4] == 4'd0);
      blank_c[k] = all_zero_c;
    end
    if (ovf_nxt_c) begin
      blank_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_c) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q       <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd_out    <= '0;
      overflow   <= 1'b0;
      blank_mask <= BLANK_RST;
    end else begin
      busy <= (state_nxt == SHIFT);
      done <= (state_nxt == DONE);
      if (start_ok_c) begin
        op_q  <= bin_in;
        acc_q <= '0;
        ovf_q <= 1'b0;
        cnt_q <= '0;
      end else if (state == SHIFT) begin
        op_q  <= {op_q[BIN_WIDTH-2:0], 1'b0};
        acc_q <= acc_nxt_c;
        ovf_q <= ovf_nxt_c;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (last_c) begin
        bcd_out    <= acc_nxt_c;
        overflow   <= ovf_nxt_c;
        blank_mask <= blank_c;
      end
    end
  end

endmodule
